// File: rtl/prog_launcher.sv
// Purpose : host-side sequencer that launches a program on the core, times its run and reports completion.
// Latency : start rises 1 cycle after the accepting edge; response 1 cycle after done (or timeout) is sampled.
// Backpres: a single launch in flight; req_ready stays low until the completion record has been taken.
//
// Ports:
//   CLK, RST_N              clock and synchronous active-low reset
//   req_valid/req_ready     launch request handshake, req_addr = program start address
//   start, start_addr       core run interface (start pulse START_CYCLES long, address held until next launch)
//   done                    core program-complete level
//   rsp_valid/rsp_ready     completion record handshake, rsp_cycles = run cycles, rsp_timeout = aborted
//   busy                    registered, high whenever the sequencer is not idle
// Optional: define PROG_LAUNCHER_STATS_EN to add stat_launches / stat_timeouts saturating counters.
module prog_launcher #(
    parameter int               START_CYCLES = 2,
    parameter int               CNT_W        = 16,
    parameter logic [CNT_W-1:0] TIMEOUT      = 16'hFFFF
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             req_valid,
    input  logic [7:0]       req_addr,
    output logic             req_ready,
    output logic             start,
    output logic [7:0]       start_addr,
    input  logic             done,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [CNT_W-1:0] rsp_cycles,
    output logic             rsp_timeout,
    output logic             busy
`ifdef PROG_LAUNCHER_STATS_EN
    ,
    output logic [15:0]      stat_launches,
    output logic [7:0]       stat_timeouts
`endif
);

    localparam int SC_W = (START_CYCLES < 2) ? 1 : $clog2(START_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        RUN    = 2'd2,
        REPORT = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic             start_nxt;
    logic [7:0]       start_addr_nxt;
    logic             rsp_valid_nxt;
    logic [CNT_W-1:0] rsp_cycles_nxt;
    logic             rsp_timeout_nxt;
    logic [SC_W-1:0]  start_cnt, start_cnt_nxt;
    logic [CNT_W-1:0] run_cnt, run_cnt_nxt;
    logic [CNT_W-1:0] run_inc;
    logic [CNT_W-1:0] run_sat;

    // run_inc is the count including the current cycle; run_sat is the
    // same value clamped so the reported count never wraps to zero.
    assign run_inc   = run_cnt + CNT_W'(1);
    assign run_sat   = (run_cnt == {CNT_W{1'b1}}) ? run_cnt : run_inc;
    assign req_ready = (state == IDLE);

    always_comb begin
        state_nxt       = state;
        start_nxt       = start;
        start_addr_nxt  = start_addr;
        rsp_valid_nxt   = rsp_valid;
        rsp_cycles_nxt  = rsp_cycles;
        rsp_timeout_nxt = rsp_timeout;
        start_cnt_nxt   = start_cnt;
        run_cnt_nxt     = run_cnt;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    start_addr_nxt = req_addr;
                    start_nxt      = 1'b1;
                    start_cnt_nxt  = SC_W'(1);
                    state_nxt      = START;
                end
            end
            START: begin
                // done is deliberately not looked at here: it may still be
                // high from the previous program.
                if (start_cnt == SC_W'(START_CYCLES)) begin
                    start_nxt   = 1'b0;
                    run_cnt_nxt = '0;
                    state_nxt   = RUN;
                end else begin
                    start_cnt_nxt = start_cnt + SC_W'(1);
                end
            end
            RUN: begin
                run_cnt_nxt = run_sat;
                // done takes priority when it lands on the timeout cycle.
                if (done) begin
                    rsp_cycles_nxt  = run_sat;
                    rsp_timeout_nxt = 1'b0;
                    rsp_valid_nxt   = 1'b1;
                    state_nxt       = REPORT;
                end else if (run_inc == TIMEOUT) begin
                    rsp_cycles_nxt  = TIMEOUT;
                    rsp_timeout_nxt = 1'b1;
                    rsp_valid_nxt   = 1'b1;
                    state_nxt       = REPORT;
                end
            end
            REPORT: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state       <= IDLE;
            start       <= 1'b0;
            start_addr  <= 8'd0;
            rsp_valid   <= 1'b0;
            rsp_cycles  <= '0;
            rsp_timeout <= 1'b0;
            busy        <= 1'b0;
            start_cnt   <= '0;
            run_cnt     <= '0;
        end else begin
            state       <= state_nxt;
            start       <= start_nxt;
            start_addr  <= start_addr_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_cycles  <= rsp_cycles_nxt;
            rsp_timeout <= rsp_timeout_nxt;
            busy        <= (state_nxt != IDLE);
            start_cnt   <= start_cnt_nxt;
            run_cnt     <= run_cnt_nxt;
        end
    end

`ifdef PROG_LAUNCHER_STATS_EN
    // rsp_valid is high exactly while in REPORT, so this is the response handshake.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            stat_launches <= 16'd0;
            stat_timeouts <= 8'd0;
        end else if (state == REPORT && rsp_ready) begin
            if (stat_launches != 16'hFFFF) begin
                stat_launches <= stat_launches + 16'd1;
            end
            if (rsp_timeout && stat_timeouts != 8'hFF) begin
                stat_timeouts <= stat_timeouts + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_prog_launcher.sv
// Purpose : self-checking bench for prog_launcher with a behavioural core model and response scoreboard.
// Latency : expected records are queued at request time and retired at each response handshake.
// Backpres: exercises response stalls and a request held valid across back-to-back launches.
module tb_prog_launcher;

    localparam int          START_CYCLES = 2;
    localparam int          CNT_W        = 16;
    localparam logic [15:0] TIMEOUT      = 16'd20;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic             req_valid;
    logic [7:0]       req_addr;
    logic             req_ready;
    logic             start;
    logic [7:0]       start_addr;
    logic             done;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [CNT_W-1:0] rsp_cycles;
    logic             rsp_timeout;
    logic             busy;
`ifdef PROG_LAUNCHER_STATS_EN
    logic [15:0]      stat_launches;
    logic [7:0]       stat_timeouts;
`endif

    prog_launcher #(
        .START_CYCLES (START_CYCLES),
        .CNT_W        (CNT_W),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_ready    (req_ready),
        .start        (start),
        .start_addr   (start_addr),
        .done         (done),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_cycles   (rsp_cycles),
        .rsp_timeout  (rsp_timeout),
        .busy         (busy)
`ifdef PROG_LAUNCHER_STATS_EN
        ,
        .stat_launches(stat_launches),
        .stat_timeouts(stat_timeouts)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] cycles;
        logic        tmo;
        logic [7:0]  addr;
    } exp_t;

    exp_t sb[$];
    int   plan[$];
    int   checks = 0;
    int   errors = 0;
    int   n_done = 0;
    bit   stale_mode = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected record: the core's done cycle if it lands at or before the
    // timeout cycle (done wins a tie), otherwise a timeout at TIMEOUT.
    task automatic push_exp(input logic [7:0] a, input int at);
        exp_t e;
        if (at > 0 && at <= int'(TIMEOUT)) begin
            e.cycles = 16'(at);
            e.tmo    = 1'b0;
        end else begin
            e.cycles = TIMEOUT;
            e.tmo    = 1'b1;
        end
        e.addr = a;
        sb.push_back(e);
        plan.push_back(at);
    endtask

    task automatic wait_accept();
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!(req_valid && req_ready) && n < 100);
        if (!(req_valid && req_ready)) chk("accept_wait", 0, 1);
        @(posedge CLK);
        #1;
    endtask

    task automatic launch(input logic [7:0] a, input int at);
        push_exp(a, at);
        req_addr  = a;
        req_valid = 1'b1;
        wait_accept();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!(sb.size() == 0 && !busy) && n < budget);
        if (!(sb.size() == 0 && !busy)) chk("idle_wait", 0, 1);
        @(posedge CLK);
        #1;
    endtask

    // Core model: done rises in the Nth cycle after start falls (N from
    // plan, 0 = never) and stays high until the next start; in stale mode
    // done also mirrors start during the start phase.
    initial begin : core_model
        bit prev_start;
        bit in_run;
        int run_cyc;
        int cur_at;
        prev_start = 1'b0;
        in_run     = 1'b0;
        run_cyc    = 0;
        cur_at     = 0;
        done       = 1'b0;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                in_run  = 1'b0;
                run_cyc = 0;
            end else if (start) begin
                if (!prev_start) begin
                    if (plan.size() > 0) cur_at = plan.pop_front();
                    else cur_at = 0;
                end
                in_run  = 1'b0;
                run_cyc = 0;
            end else if (prev_start) begin
                in_run  = 1'b1;
                run_cyc = 1;
            end else if (in_run) begin
                run_cyc++;
            end
            prev_start = start;
            done = (stale_mode && start) || (in_run && cur_at > 0 && run_cyc >= cur_at);
        end
    end

    initial begin : monitor
        int          hi_cnt;
        bit          have_snap;
        bit          hs_prev;
        logic [15:0] snap_cyc;
        logic        snap_to;
        exp_t        e;
        hi_cnt    = 0;
        have_snap = 1'b0;
        hs_prev   = 1'b0;
        snap_cyc  = '0;
        snap_to   = 1'b0;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                hi_cnt    = 0;
                have_snap = 1'b0;
                hs_prev   = 1'b0;
            end else begin
                if (hs_prev) chk("req_ready_after_hs", req_ready, 1);
                hs_prev = 1'b0;
                if (start) begin
                    hi_cnt++;
                end else if (hi_cnt != 0) begin
                    chk("start_width", hi_cnt, START_CYCLES);
                    hi_cnt = 0;
                end
                if (rsp_valid) begin
                    chk("req_ready_in_report", req_ready, 0);
                    if (have_snap) begin
                        chk("hold_cycles", rsp_cycles, snap_cyc);
                        chk("hold_timeout", rsp_timeout, snap_to);
                    end else begin
                        snap_cyc  = rsp_cycles;
                        snap_to   = rsp_timeout;
                        have_snap = 1'b1;
                    end
                    if (rsp_ready) begin
                        if (sb.size() == 0) begin
                            chk("unexpected_rsp", 1, 0);
                        end else begin
                            e = sb.pop_front();
                            chk("rsp_cycles", rsp_cycles, e.cycles);
                            chk("rsp_timeout", rsp_timeout, e.tmo);
                            chk("start_addr", start_addr, e.addr);
                            chk("start_low_in_report", start, 0);
                            n_done++;
                        end
                        have_snap = 1'b0;
                        hs_prev   = 1'b1;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int  n;
        bit  seen;
        RST_N     = 1'b0;
        req_valid = 1'b0;
        req_addr  = 8'h00;
        rsp_ready = 1'b1;
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;

        @(negedge CLK);
        chk("rst_start", start, 0);
        chk("rst_start_addr", start_addr, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_cycles", rsp_cycles, 0);
        chk("rst_rsp_timeout", rsp_timeout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 1);
`ifdef PROG_LAUNCHER_STATS_EN
        chk("rst_stat_launches", stat_launches, 0);
        chk("rst_stat_timeouts", stat_timeouts, 0);
`endif
        @(posedge CLK);
        #1;

        // Basic launch, then stale done held through the start phase.
        launch(8'h10, 5);
        wait_idle(200);
        stale_mode = 1'b1;
        launch(8'h21, 3);
        wait_idle(200);
        stale_mode = 1'b0;

        // Timeout, coincident done/timeout, one-before-timeout, shortest run.
        launch(8'h33, 0);
        wait_idle(200);
        launch(8'h44, int'(TIMEOUT));
        wait_idle(200);
        launch(8'h45, int'(TIMEOUT) - 1);
        wait_idle(200);
        launch(8'h46, 1);
        wait_idle(200);

        // Response backpressure with a second request held valid.
        rsp_ready = 1'b0;
        push_exp(8'h20, 3);
        req_addr  = 8'h20;
        req_valid = 1'b1;
        wait_accept();
        push_exp(8'h40, 4);
        req_addr = 8'h40;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!rsp_valid && n < 100);
        chk("bp_rsp_seen", rsp_valid, 1);
        repeat (4) @(negedge CLK);
        @(posedge CLK);
        #1 rsp_ready = 1'b1;
        wait_accept();
        req_valid = 1'b0;
        wait_idle(200);
`ifdef PROG_LAUNCHER_STATS_EN
        chk("stat_launches", stat_launches, n_done);
        chk("stat_timeouts", stat_timeouts, 1);
`endif

        // Reset in the middle of a run.
        req_addr  = 8'h55;
        req_valid = 1'b1;
        plan.push_back(0);
        wait_accept();
        req_valid = 1'b0;
        repeat (6) @(posedge CLK);
        #1;
        chk("busy_before_reset", busy, 1);
        RST_N = 1'b0;
        plan.delete();
        @(posedge CLK);
        #1 RST_N = 1'b1;
        @(negedge CLK);
        chk("mid_rst_start", start, 0);
        chk("mid_rst_start_addr", start_addr, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_rsp_cycles", rsp_cycles, 0);
        chk("mid_rst_rsp_timeout", rsp_timeout, 0);
        chk("mid_rst_busy", busy, 0);
`ifdef PROG_LAUNCHER_STATS_EN
        chk("mid_rst_stat_launches", stat_launches, 0);
        chk("mid_rst_stat_timeouts", stat_timeouts, 0);
`endif
        seen = 1'b0;
        repeat (30) begin
            @(negedge CLK);
            if (rsp_valid) seen = 1'b1;
        end
        chk("no_rsp_after_reset", seen, 0);
        @(posedge CLK);
        #1;

        // Recovery after reset.
        launch(8'h66, 2);
        wait_idle(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
